id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
Decode stage and ID/EX pipeline register of the RV32I core, directly downstream of the register file. Drives rs1/rs2 read addresses to the register file and captures DataA/DataB, with write-through bypass from writeback. Generates immediates and decode fields, and detects load-use hazards, stalling fetch for one bubble. Uses a valid/ready handshake with fetch (upstream) and execute (downstream).

Parameters:
XLEN, 32, datapath width
RESET_PC, 32'h0000_0000, reset value of ex_pc

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active-low
flush  in  1  branch/jump redirect; kill the stage contents
if_valid  in  1  fetch presents an instruction
if_instr  in  32  instruction word
if_pc  in  XLEN  instruction PC
id_ready  out  1  stage accepts if_instr this cycle
rs1  out  5  register file read address A (= if_instr[19:15])
rs2  out  5  register file read address B (= if_instr[24:20])
DataA  in  XLEN  register file read data A
DataB  in  XLEN  register file read data B
wb_rd  in  5  writeback destination (same value driven to reg_file rd)
wb_regWEn  in  1  writeback write enable
wb_data  in  XLEN  writeback data (DataD)
ex_ready  in  1  execute accepts ex_* this cycle
ex_valid  out  1  ex_* fields valid
ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN each  registered operands
ex_rd  out  5  destination register
ex_opcode  out  7  instr[6:0]
ex_funct3  out  3  instr[14:12]
ex_funct7b5  out  1  instr[30]
ex_reg_we  out  1  instruction writes rd (rd != 0 and opcode not STORE/BRANCH)
ex_is_load  out  1  opcode == 7'b0000011

Behaviour:
- All ex_* registers update only on posedge clk; reset is synchronous (rst_n low at edge): ex_valid=0, ex_pc=RESET_PC, all other ex_* = 0. id_ready is combinational, 0 while rst_n low.
- advance = !ex_valid | ex_ready.
- hazard = ex_valid & ex_is_load & ex_rd!=0 & ((use_rs1 & ex_rd==rs1) | (use_rs2 & ex_rd==rs2)).
  - use_rs1 false for LUI, AUIPC, JAL.
  - use_rs2 true only for OP (0110011), STORE, BRANCH.
- id_ready = advance & !hazard & rst_n.
- Per edge, priority high to low:
  1. reset.
  2. flush: ex_valid<=0; incoming instruction dropped regardless of id_ready.
  3. advance & hazard: ex_valid<=0 (bubble); fetch holds if_instr.
  4. advance & if_valid: capture all fields, ex_valid<=1.
  5. advance & !if_valid: ex_valid<=0.
  6. !advance: hold all ex_* unchanged.
- Latency: one cycle from accepted if_instr to ex_valid. A load-use dependency costs exactly one bubble; the dependent instruction is accepted the following cycle.
- Immediates (sign-extended to XLEN):
  - I: OP-IMM, LOAD, JALR
  - S: STORE
  - B: BRANCH, bit0=0
  - U: LUI, AUIPC, low 12 bits zero
  - J: JAL, bit0=0
  - Other opcodes: imm=0.
- Operand capture: ex_rs1_data = bypass ? wb_data : DataA, where bypass = wb_regWEn & wb_rd!=0 & wb_rd==rs1. Same rule for rs2/DataB. Address 0 never bypasses and captures DataA/DataB as driven.
- A stalled instruction (!advance) does not re-sample operands. A writeback to a held source register is the downstream forwarding unit's responsibility.

Optional Feature:
WB_BYPASS_EN. Defined: write-through bypass exactly as above. Undefined: operands are always DataA/DataB, and the stage additionally stalls (id_ready=0, bubble inserted, as for hazard) when wb_regWEn & wb_rd!=0 & wb_rd matches a used rs1/rs2.

Test Plan:
- Reset: rst_n=0 for 2 edges with if_valid=1 -> ex_valid=0, ex_pc=RESET_PC, ex_imm=0; id_ready=0 during reset.
- ADDI x5,x0,-1 (32'hFFF00293) at pc 0x40, ex_ready=1 -> next cycle ex_valid=1, ex_imm=32'hFFFF_FFFF, ex_rd=5, ex_reg_we=1, ex_pc=0x40.
- LW x6,0(x1), then ADD x7,x6,x2 -> one cycle id_ready=0 with ex_valid=0 bubble; ADD captured the following cycle.
- ADD x3,x4,x5 with wb_regWEn=1, wb_rd=4, wb_data=0x1234, DataA=0x0 -> ex_rs1_data=0x1234 (WB_BYPASS_EN). Same with wb_rd=0 -> ex_rs1_data=DataA.
- ex_valid=1, ex_ready=0 for 3 cycles while if_valid=1 -> ex_* stable, id_ready=0; on ex_ready=1 the new instruction is captured.
- flush=1 coincident with if_valid=1 and ex_ready=1 -> ex_valid=0 next cycle; the instruction is not captured.

Source files
------------

// File: rtl/id_ex_stage.sv
// RV32I decode stage and ID/EX pipeline register with load-use stall.
// Build option WB_BYPASS_EN: bypass writeback data into operands; otherwise stall on writeback conflicts.
module id_ex_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic            id_ready,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  input  logic [XLEN-1:0] DataA,
  input  logic [XLEN-1:0] DataB,
  input  logic [4:0]      wb_rd,
  input  logic            wb_regWEn,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rd,
  output logic [6:0]      ex_opcode,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7b5,
  output logic            ex_reg_we,
  output logic            ex_is_load
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic            ex_valid_q;
  logic [XLEN-1:0] ex_pc_q, ex_rs1_data_q, ex_rs2_data_q, ex_imm_q;
  logic [4:0]      ex_rd_q;
  logic [6:0]      ex_opcode_q;
  logic [2:0]      ex_funct3_q;
  logic            ex_funct7b5_q, ex_reg_we_q, ex_is_load_q;

  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic            use_rs1, use_rs2, advance, load_use, stall;
  logic [31:0]     imm32;
  logic [XLEN-1:0] ex_rs1_data_d, ex_rs2_data_d, ex_imm_d;
  logic            ex_reg_we_d;

  assign opcode = if_instr[6:0];
  assign rd     = if_instr[11:7];
  assign rs1    = if_instr[19:15];
  assign rs2    = if_instr[24:20];

  assign use_rs1 = !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
  assign use_rs2 = (opcode == OP_REG) || (opcode == OP_STORE) || (opcode == OP_BRANCH);

  assign advance  = !ex_valid_q || ex_ready;
  assign load_use = ex_valid_q && ex_is_load_q && (ex_rd_q != '0) &&
                    ((use_rs1 && (ex_rd_q == rs1)) || (use_rs2 && (ex_rd_q == rs2)));

`ifdef WB_BYPASS_EN
  assign stall         = load_use;
  assign ex_rs1_data_d = (wb_regWEn && (wb_rd != '0) && (wb_rd == rs1)) ? wb_data : DataA;
  assign ex_rs2_data_d = (wb_regWEn && (wb_rd != '0) && (wb_rd == rs2)) ? wb_data : DataB;
`else
  // Without bypass, an in-flight writeback to a source register must land before the read.
  logic wb_conflict;
  logic unused_wb_data;
  assign wb_conflict    = wb_regWEn && (wb_rd != '0) &&
                          ((use_rs1 && (wb_rd == rs1)) || (use_rs2 && (wb_rd == rs2)));
  assign stall          = load_use || wb_conflict;
  assign ex_rs1_data_d  = DataA;
  assign ex_rs2_data_d  = DataB;
  assign unused_wb_data = ^wb_data;
`endif

  assign id_ready = advance && !stall && rst_n;

  always_comb begin
    imm32 = '0;
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR: imm32 = {{20{if_instr[31]}}, if_instr[31:20]};
      OP_STORE:  imm32 = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
      OP_BRANCH: imm32 = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                          if_instr[30:25], if_instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC: imm32 = {if_instr[31:12], 12'b0};
      OP_JAL:    imm32 = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                          if_instr[20], if_instr[30:21], 1'b0};
      default:   imm32 = '0;
    endcase
  end

  assign ex_imm_d    = XLEN'($signed(imm32));
  assign ex_reg_we_d = (rd != '0) && (opcode != OP_STORE) && (opcode != OP_BRANCH);

  // Bubbles and flushes only clear ex_valid; payload fields keep their last value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid_q    <= 1'b0;
      ex_pc_q       <= RESET_PC;
      ex_rs1_data_q <= '0;
      ex_rs2_data_q <= '0;
      ex_imm_q      <= '0;
      ex_rd_q       <= '0;
      ex_opcode_q   <= '0;
      ex_funct3_q   <= '0;
      ex_funct7b5_q <= 1'b0;
      ex_reg_we_q   <= 1'b0;
      ex_is_load_q  <= 1'b0;
    end else if (flush) begin
      ex_valid_q <= 1'b0;
    end else if (advance) begin
      if (stall) begin
        ex_valid_q <= 1'b0;
      end else if (if_valid) begin
        ex_valid_q    <= 1'b1;
        ex_pc_q       <= if_pc;
        ex_rs1_data_q <= ex_rs1_data_d;
        ex_rs2_data_q <= ex_rs2_data_d;
        ex_imm_q      <= ex_imm_d;
        ex_rd_q       <= rd;
        ex_opcode_q   <= opcode;
        ex_funct3_q   <= if_instr[14:12];
        ex_funct7b5_q <= if_instr[30];
        ex_reg_we_q   <= ex_reg_we_d;
        ex_is_load_q  <= (opcode == OP_LOAD);
      end else begin
        ex_valid_q <= 1'b0;
      end
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_pc       = ex_pc_q;
  assign ex_rs1_data = ex_rs1_data_q;
  assign ex_rs2_data = ex_rs2_data_q;
  assign ex_imm      = ex_imm_q;
  assign ex_rd       = ex_rd_q;
  assign ex_opcode   = ex_opcode_q;
  assign ex_funct3   = ex_funct3_q;
  assign ex_funct7b5 = ex_funct7b5_q;
  assign ex_reg_we   = ex_reg_we_q;
  assign ex_is_load  = ex_is_load_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_id_ex_stage;
  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111, BRANCH = 7'b1100011, LOAD = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011, OPIMM = 7'b0010011, OPREG = 7'b0110011;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  logic clk = 1'b0;
  logic rst_n, flush, if_valid, wb_regWEn, ex_ready;
  logic [31:0] if_instr, if_pc, DataA, DataB, wb_data;
  logic [4:0]  wb_rd;
  logic        id_ready, ex_valid, ex_funct7b5, ex_reg_we, ex_is_load;
  logic [4:0]  rs1, rs2, ex_rd;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;

  int checks = 0;
  int errors = 0;

  // Reference model of what the execute stage should be holding.
  bit          m_valid, m_we, m_load;
  logic [31:0] m_pc, m_a, m_b, m_imm;
  logic [4:0]  m_rd;
  logic [6:0]  m_op;
  logic [2:0]  m_f3;
  logic        m_f7b5;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc(if_pc), .id_ready(id_ready), .rs1(rs1), .rs2(rs2), .DataA(DataA), .DataB(DataB),
    .wb_rd(wb_rd), .wb_regWEn(wb_regWEn), .wb_data(wb_data), .ex_ready(ex_ready),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
    .ex_funct7b5(ex_funct7b5), .ex_reg_we(ex_reg_we), .ex_is_load(ex_is_load));

  // Immediate as a number, built from weighted instruction fields.
  function automatic logic [31:0] ref_imm(input logic [31:0] ins);
    int s;
    int neg;
    s   = int'(ins);
    neg = ins[31] ? 1 : 0;
    case (ins[6:0])
      OPIMM, LOAD, JALR: return 32'(s >>> 20);
      STORE:  return 32'((s >>> 25) * 32 + int'(ins[11:7]));
      BRANCH: return 32'(-4096 * neg + 2048 * int'(ins[7]) + 32 * int'(ins[30:25]) + 2 * int'(ins[11:8]));
      LUI, AUIPC: return ins & 32'hFFFF_F000;
      JAL:    return 32'(-1048576 * neg + 4096 * int'(ins[19:12]) + 2048 * int'(ins[20]) + 2 * int'(ins[30:21]));
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit reads_reg(input logic [31:0] ins, input logic [4:0] r);
    bit a, b;
    a = !(ins[6:0] inside {LUI, AUIPC, JAL}) && (ins[19:15] == r);
    b = (ins[6:0] inside {OPREG, STORE, BRANCH}) && (ins[24:20] == r);
    return (r != 5'd0) && (a || b);
  endfunction

  function automatic bit m_stall();
    bit s;
    s = m_valid && m_load && reads_reg(if_instr, m_rd);
`ifndef WB_BYPASS_EN
    s = s || (wb_regWEn && reads_reg(if_instr, wb_rd));
`endif
    return s;
  endfunction

  function automatic bit exp_ready();
    return rst_n && (!m_valid || ex_ready) && !m_stall();
  endfunction

  // Advance the model with the current inputs, then clock the DUT.
  task automatic tick();
    if (!rst_n) begin
      m_valid = 0; m_pc = RESET_PC; m_a = 0; m_b = 0; m_imm = 0; m_rd = 0;
      m_op = 0; m_f3 = 0; m_f7b5 = 0; m_we = 0; m_load = 0;
    end else if (flush) begin
      m_valid = 0;
    end else if (m_valid && !ex_ready) begin
      m_valid = m_valid;
    end else if (m_stall()) begin
      m_valid = 0;
    end else if (if_valid) begin
      m_valid = 1;
      m_pc    = if_pc;
      m_a     = DataA;
      m_b     = DataB;
`ifdef WB_BYPASS_EN
      if (wb_regWEn && wb_rd != 0 && wb_rd == if_instr[19:15]) m_a = wb_data;
      if (wb_regWEn && wb_rd != 0 && wb_rd == if_instr[24:20]) m_b = wb_data;
`endif
      m_imm  = ref_imm(if_instr);
      m_rd   = if_instr[11:7];
      m_op   = if_instr[6:0];
      m_f3   = if_instr[14:12];
      m_f7b5 = if_instr[30];
      m_we   = (m_rd != 0) && !(m_op inside {STORE, BRANCH});
      m_load = (m_op == LOAD);
    end else begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; flush = 0; if_valid = 1; if_instr = 32'h00A0_0093; if_pc = 32'h10;
    DataA = 32'h55; DataB = 32'h66; wb_rd = 0; wb_regWEn = 0; wb_data = 0; ex_ready = 1;
    repeat (2) begin
      #1;
      checks++;
      if (id_ready !== 1'b0) begin errors++; $display("FAIL reset_id_ready: got %0b want 0", id_ready); end
      tick();
    end
    checks++;
    if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid: got %0b want 0", ex_valid); end
    checks++;
    if (ex_pc !== RESET_PC) begin errors++; $display("FAIL reset_ex_pc: got %h want %h", ex_pc, RESET_PC); end
    checks++;
    if (ex_imm !== 32'h0) begin errors++; $display("FAIL reset_ex_imm: got %h want 0", ex_imm); end
    checks++;
    if (ex_rd !== 5'd0) begin errors++; $display("FAIL reset_ex_rd: got %0d want 0", ex_rd); end
    rst_n = 1;
  endtask

  task automatic test_addi();
    if_valid = 1; if_instr = 32'hFFF0_0293; if_pc = 32'h40; ex_ready = 1;
    #1;
    checks++;
    if (id_ready !== 1'b1) begin errors++; $display("FAIL addi_ready: got %0b want 1", id_ready); end
    tick();
    checks++;
    if (ex_valid !== 1'b1) begin errors++; $display("FAIL addi_valid: got %0b want 1", ex_valid); end
    checks++;
    if (ex_imm !== 32'hFFFF_FFFF) begin errors++; $display("FAIL addi_imm: got %h want ffffffff", ex_imm); end
    checks++;
    if (ex_rd !== 5'd5 || ex_reg_we !== 1'b1) begin
      errors++; $display("FAIL addi_rd_we: got rd=%0d we=%0b want rd=5 we=1", ex_rd, ex_reg_we);
    end
    checks++;
    if (ex_pc !== 32'h40) begin errors++; $display("FAIL addi_pc: got %h want 40", ex_pc); end
  endtask

  task automatic test_load_use();
    if_instr = 32'h0000_A303; if_pc = 32'h44; ex_ready = 1; if_valid = 1;
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_is_load !== 1'b1) begin
      errors++; $display("FAIL lw_capture: got valid=%0b load=%0b want 1 1", ex_valid, ex_is_load);
    end
    if_instr = 32'h0023_03B3; if_pc = 32'h48;
    #1;
    checks++;
    if (id_ready !== 1'b0) begin errors++; $display("FAIL loaduse_ready: got %0b want 0", id_ready); end
    tick();
    checks++;
    if (ex_valid !== 1'b0) begin errors++; $display("FAIL loaduse_bubble: got %0b want 0", ex_valid); end
    checks++;
    if (id_ready !== 1'b1) begin errors++; $display("FAIL loaduse_release: got %0b want 1", id_ready); end
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd7 || ex_pc !== 32'h48) begin
      errors++; $display("FAIL add_after_bubble: got v=%0b rd=%0d pc=%h want 1 7 48", ex_valid, ex_rd, ex_pc);
    end
  endtask

  task automatic test_bypass();
    if_instr = 32'h0052_01B3; if_pc = 32'h50; if_valid = 1; ex_ready = 1;
    wb_regWEn = 1; wb_rd = 4; wb_data = 32'h1234; DataA = 32'h0;
`ifdef WB_BYPASS_EN
    tick();
    checks++;
    if (ex_rs1_data !== 32'h1234) begin errors++; $display("FAIL bypass_rs1: got %h want 1234", ex_rs1_data); end
`else
    #1;
    checks++;
    if (id_ready !== 1'b0) begin errors++; $display("FAIL wbstall_ready: got %0b want 0", id_ready); end
    tick();
    checks++;
    if (ex_valid !== 1'b0) begin errors++; $display("FAIL wbstall_bubble: got %0b want 0", ex_valid); end
`endif
    wb_rd = 0; DataA = 32'hCAFE; if_pc = 32'h54;
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_rs1_data !== 32'hCAFE) begin
      errors++; $display("FAIL bypass_x0: got v=%0b rs1d=%h want 1 cafe", ex_valid, ex_rs1_data);
    end
    wb_regWEn = 0;
  endtask

  task automatic test_backpressure();
    if_instr = 32'hFFF0_0293; if_pc = 32'h80; if_valid = 1; ex_ready = 1;
    tick();
    ex_ready = 0; if_instr = 32'h0052_01B3; if_pc = 32'h84;
    repeat (3) begin
      #1;
      checks++;
      if (id_ready !== 1'b0) begin errors++; $display("FAIL hold_ready: got %0b want 0", id_ready); end
      tick();
      checks++;
      if (ex_valid !== 1'b1 || ex_pc !== 32'h80 || ex_imm !== 32'hFFFF_FFFF) begin
        errors++; $display("FAIL hold_stable: got v=%0b pc=%h imm=%h want 1 80 ffffffff", ex_valid, ex_pc, ex_imm);
      end
    end
    ex_ready = 1;
    #1;
    checks++;
    if (id_ready !== 1'b1) begin errors++; $display("FAIL hold_release: got %0b want 1", id_ready); end
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_pc !== 32'h84 || ex_rd !== 5'd3) begin
      errors++; $display("FAIL hold_next: got v=%0b pc=%h rd=%0d want 1 84 3", ex_valid, ex_pc, ex_rd);
    end
  endtask

  task automatic test_flush();
    flush = 1; if_valid = 1; ex_ready = 1; if_instr = 32'h0010_0513; if_pc = 32'h90;
    tick();
    flush = 0; if_valid = 0;
    checks++;
    if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %0b want 0", ex_valid); end
    checks++;
    if (ex_pc === 32'h90) begin errors++; $display("FAIL flush_captured: got pc=%h want not 90", ex_pc); end
    tick();
  endtask

  task automatic test_random();
    logic [6:0] ops [10];
    ops = '{LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OPREG, SYSTEM};
    for (int i = 0; i < 400; i++) begin
      rst_n     = ($urandom_range(0, 49) != 0);
      flush     = ($urandom_range(0, 9) == 0);
      if_valid  = ($urandom_range(0, 4) != 0);
      ex_ready  = ($urandom_range(0, 9) < 7);
      if_instr  = $urandom;
      if_instr[6:0]   = ops[$urandom_range(0, 9)];
      if_instr[11:7]  = 5'($urandom_range(0, 3));
      if_instr[19:15] = 5'($urandom_range(0, 3));
      if_instr[24:20] = 5'($urandom_range(0, 3));
      if_pc     = $urandom & 32'hFFFF_FFFC;
      DataA     = $urandom; DataB = $urandom; wb_data = $urandom;
      wb_regWEn = $urandom_range(0, 1) != 0;
      wb_rd     = 5'($urandom_range(0, 3));
      #1;
      checks++;
      if (id_ready !== exp_ready()) begin
        errors++; $display("FAIL rnd_ready[%0d]: got %0b want %0b", i, id_ready, exp_ready());
      end
      tick();
      checks++;
      if (ex_valid !== m_valid) begin errors++; $display("FAIL rnd_valid[%0d]: got %0b want %0b", i, ex_valid, m_valid); end
      if (m_valid) begin
        checks++;
        if (ex_pc !== m_pc || ex_imm !== m_imm) begin
          errors++; $display("FAIL rnd_pc_imm[%0d]: got %h %h want %h %h", i, ex_pc, ex_imm, m_pc, m_imm);
        end
        checks++;
        if (ex_rs1_data !== m_a || ex_rs2_data !== m_b) begin
          errors++; $display("FAIL rnd_operands[%0d]: got %h %h want %h %h", i, ex_rs1_data, ex_rs2_data, m_a, m_b);
        end
        checks++;
        if (ex_rd !== m_rd || ex_opcode !== m_op || ex_funct3 !== m_f3 || ex_funct7b5 !== m_f7b5 ||
            ex_reg_we !== m_we || ex_is_load !== m_load) begin
          errors++;
          $display("FAIL rnd_decode[%0d]: got rd=%0d op=%b f3=%0d f7=%0b we=%0b ld=%0b want rd=%0d op=%b f3=%0d f7=%0b we=%0b ld=%0b",
                   i, ex_rd, ex_opcode, ex_funct3, ex_funct7b5, ex_reg_we, ex_is_load,
                   m_rd, m_op, m_f3, m_f7b5, m_we, m_load);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load_use();
    test_bypass();
    test_backpressure();
    test_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
